// File: rtl/i2c_pkg.sv
// Shared types for the write-only I2C master: FSM states, quarter-phase type, word width.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    DATA,
    ACK2,
    STOP
  } state_t;

  typedef logic [1:0] quarter_t;

  localparam int I2C_WORD_W = 16;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream interface: tdata/tvalid/tready only.
interface axis_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport slave  (input  tdata, input  tvalid, output tready);
  modport master (output tdata, output tvalid, input  tready);

endinterface

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one-clock pulse every DIVIDER clocks while enabled; i_hold freezes it.
module i2c_tick_gen #(
  parameter int DIVIDER = 1
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic i_en,
  input  logic i_hold,
  output logic o_tick
);

  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && !i_hold && (r_cnt == CNT_LAST);

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_wr.sv
// Write-only I2C master: each accepted 16-bit word {addr, rw, data} becomes START/addr/ACK/data/ACK/STOP.
// Optional SCL clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_wr
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int I2C_FREQ   = 100_000
) (
  input  logic  clk_i,
  input  logic  arst_i,
  axis_if.slave s_axis,
  input  logic  sda_i,
  input  logic  scl_i,
  output logic  sda_oe_o,
  output logic  scl_oe_o,
  output logic  busy_o,
  output logic  nack_o
);

  localparam int DIVIDER = CLK_FREQ / (4 * I2C_FREQ);
  localparam logic [I2C_WORD_W-1:0] RW_CLR = 16'hFEFF;

  if (DATA_WIDTH != I2C_WORD_W) begin : g_bad_width
    $error("i2c_master_wr: DATA_WIDTH must be 16");
  end
  if (DIVIDER < 1) begin : g_bad_div
    $error("i2c_master_wr: CLK_FREQ/(4*I2C_FREQ) must be >= 1");
  end

  state_t                r_state;
  state_t                w_state_nxt;
  quarter_t              r_q;
  logic [2:0]            r_bit_cnt;
  logic [I2C_WORD_W-1:0] r_shift;
  logic                  r_nack;

  logic       w_tick;
  logic       w_hold;
  logic       w_busy;
  logic       w_accept;
  logic       w_bit_end;
  logic       w_last_bit;
  logic [7:0] w_tx_byte;
  logic [2:0] w_bit_idx;
  logic       w_tx_bit;
  logic       w_sda_oe;
  logic       w_scl_oe;

`ifdef I2C_CLK_STRETCH_EN
  // A slave holding SCL low freezes the SCL-high quarter, so ACK sampling waits for SCL high.
  assign w_hold = (r_q == 2'd2) && !scl_i;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_hold       = 1'b0;
`endif

  assign w_busy     = (r_state != IDLE);
  assign w_accept   = (r_state == IDLE) && s_axis.tvalid;
  assign w_bit_end  = w_tick && (r_q == 2'd3);
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_tx_byte  = (r_state == DATA) ? r_shift[7:0] : r_shift[15:8];
  assign w_bit_idx  = ~r_bit_cnt;
  assign w_tx_bit   = w_tx_byte[w_bit_idx];

  i2c_tick_gen #(.DIVIDER(DIVIDER)) u_tick_gen (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .i_en   (w_busy),
    .i_hold (w_hold),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (s_axis.tvalid)            w_state_nxt = START;
      START:   if (w_bit_end)                w_state_nxt = ADDR;
      ADDR:    if (w_bit_end && w_last_bit)  w_state_nxt = ACK1;
      ACK1:    if (w_bit_end)                w_state_nxt = r_nack ? STOP : DATA;
      DATA:    if (w_bit_end && w_last_bit)  w_state_nxt = ACK2;
      ACK2:    if (w_bit_end)                w_state_nxt = STOP;
      STOP:    if (w_bit_end)                w_state_nxt = IDLE;
      default:                               w_state_nxt = IDLE;
    endcase
  end

  // SCL is pulled in q0-q1 of data/ack bits; START and STOP shape SDA against a high SCL.
  always_comb begin
    w_sda_oe = 1'b0;
    w_scl_oe = 1'b0;
    case (r_state)
      START: w_sda_oe = r_q[1];
      ADDR, DATA: begin
        w_scl_oe = ~r_q[1];
        w_sda_oe = ~w_tx_bit;
      end
      ACK1, ACK2: w_scl_oe = ~r_q[1];
      STOP: begin
        w_scl_oe = ~r_q[1];
        w_sda_oe = (r_q != 2'd3);
      end
      default: ;
    endcase
  end

  // NOTE: the word register is reset too; it is a handful of flops, not a memory array.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_q       <= '0;
      r_nack    <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= s_axis.tdata & RW_CLR;
      r_bit_cnt <= '0;
      r_q       <= '0;
      r_nack    <= 1'b0;
    end else if (w_tick) begin
      r_q <= r_q + 2'd1;
      if (w_bit_end && (r_state == ADDR || r_state == DATA))
        r_bit_cnt <= r_bit_cnt + 3'd1;
      if ((r_q == 2'd2) && (r_state == ACK1 || r_state == ACK2) && sda_i)
        r_nack <= 1'b1;
    end
  end

  assign s_axis.tready = (r_state == IDLE);
  assign sda_oe_o      = w_sda_oe;
  assign scl_oe_o      = w_scl_oe;
  assign busy_o        = w_busy;
  assign nack_o        = r_nack;

endmodule

// File: doc/i2c_master_wr.md
Name: i2c_master_wr

Overview:
- Write-only I2C master that sits directly downstream of the AXI-Stream FIFO and consumes its 16-bit words.
- Each accepted word becomes one complete bus transaction: START, address byte, ACK, data byte, ACK, STOP.
- Drives open-drain SCL/SDA through active-high output-enable pins.
- Reports completion status back to the control logic via busy_o and nack_o.

Parameters:
- DATA_WIDTH, 16: s_axis tdata width; must be 16 (elaboration $error otherwise).
- CLK_FREQ, 50_000_000: clk_i frequency in Hz.
- I2C_FREQ, 100_000: SCL frequency in Hz.
- DIVIDER (localparam) = CLK_FREQ/(4*I2C_FREQ): clocks per quarter-bit; elaboration $error if < 1.

Ports:
- clk_i  input  1  system clock
- arst_i  input  1  asynchronous, active-high reset
- s_axis  axis_if.slave  DATA_WIDTH  word {addr[6:0], rw, data[7:0]}; tdata, tvalid, tready used
- sda_i  input  1  sampled SDA line
- scl_i  input  1  sampled SCL line (used only with the optional feature)
- sda_oe_o  output  1  1 = pull SDA low
- scl_oe_o  output  1  1 = pull SCL low
- busy_o  output  1  transaction in progress
- nack_o  output  1  sticky: last transaction saw a NACK

Behaviour:
- Reset (async, arst_i=1):
  - state=IDLE; sda_oe_o=0, scl_oe_o=0 (both lines released); busy_o=0, nack_o=0; counters cleared.
  - Reset mid-transaction releases both lines immediately. No STOP is generated.
- Timing base:
  - Quarter tick every DIVIDER clocks.
  - Each bit-time is 4 quarters q0..q3.
  - SCL is low in q0-q1 and released in q2-q3; SDA changes only at q0 entry.
- Handshake:
  - tready=1 only in IDLE.
  - On tvalid&tready the word is latched into a shift register with bit 8 forced to 0 (write). nack_o is cleared in that same cycle.
  - busy_o=1 from the next cycle until STOP completes. tdata is not re-read during the transaction.
- FSM: IDLE -> START -> ADDR -> ACK1 -> DATA -> ACK2 -> STOP -> IDLE.
  - START (1 bit-time): q0-q1 SDA released, SCL released; q2-q3 SDA low, SCL released.
  - ADDR/DATA (8 bit-times each): MSB first. sda_oe_o = ~bit. 3-bit counter, wraps 7->0 on state exit.
  - ACK1/ACK2 (1 bit-time): SDA released; sda_i sampled on the last clock of q2. 1 = NACK.
  - NACK in ACK1: set nack_o, skip DATA, go to STOP.
  - NACK in ACK2: set nack_o, go to STOP.
  - STOP (1 bit-time): q0-q1 SCL low, SDA low; q2 SCL released, SDA low; q3 SDA released (rising SDA while SCL high).
  - Return to IDLE after STOP q3 ends. tready asserts in that IDLE cycle; back-to-back words are allowed.
- Transaction length:
  - Full transaction: 20 bit-times = 80*DIVIDER clocks from handshake to IDLE.
  - NACK-at-address transaction: 11 bit-times = 44*DIVIDER clocks.
- tvalid dropping while not in IDLE has no effect.
- nack_o holds its value until the next accepted word.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined: while in q2 of any bit-time, the quarter counter holds while scl_i==0. A slave stretching SCL delays progress, and ACK sampling occurs only after SCL is seen high.
- Undefined: scl_i is ignored and timing is purely counter-driven.

Decomposition:
- Package i2c_pkg holds:
  - state enum typedef (IDLE, START, ADDR, ACK1, DATA, ACK2, STOP);
  - quarter-phase typedef (2 bits);
  - localparam I2C_WORD_W=16.
- One sub-module, i2c_tick_gen: parameterized DIVIDER counter producing a 1-clock quarter tick, with hold input for clock stretching.

Test Plan (CLK_FREQ=400_000, I2C_FREQ=100_000 -> DIVIDER=1):
- Single write, tdata=16'hA0_5C, slave ACKs both bytes:
  - bus shows START, byte 0xA0, ACK, 0x5C, ACK, STOP;
  - busy_o high for exactly 80 clocks; nack_o=0.
- tdata=16'hA1_33 (rw bit set): address byte on bus is 0xA0 (rw forced to write).
- Address NACK (sda_i=1 in ACK1):
  - STOP follows immediately and no data byte appears;
  - busy_o high for 44 clocks; nack_o=1 until the next handshake.
- Two words presented back-to-back with tvalid held high:
  - second handshake occurs the cycle IDLE is re-entered;
  - no bus glitch between the first STOP and the second START.
- arst_i pulsed during DATA bit 3: sda_oe_o=0, scl_oe_o=0, busy_o=0 in the same cycle; next word begins with a clean START.
- With I2C_CLK_STRETCH_EN defined, scl_i held low for 10 clocks in ADDR bit 2 q2: transaction lengthens by exactly 10 clocks and the data is unchanged.
